l1_mshr_miss_ctrl: RTL and testbench

Parametrised, multi-entry miss controller for the L1 data cache. It replaces the single-outstanding-miss controller with a table of NUM_MSHR miss entries and an issue engine that performs victim writeback then line read to L2. It also routes ID-tagged L2 responses back into cache fills. It sits between the L1 tag/array logic (miss side) and the L2 request/response port.

---
 rtl/l1_mshr_miss_ctrl_if.sv | 57 +++++
 rtl/l1_mshr_miss_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_l1_mshr_miss_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mshr_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : l1_mshr_miss_ctrl_if
// Description : Bundle of the miss-side, L2 request/response and fill signals
//               of the L1 MSHR miss controller.
//               slave  : the miss controller itself
//               master : the surrounding L1 / L2 environment
//               Miss side : miss_valid/addr/dirty, victim_addr -> miss_ready,
//                           miss_merged
//               L2 side   : l2_req_valid/rw/addr/id <- l2_req_stall,
//                           l2_resp_valid/id
//               Array side: wb_rd_en, fill_valid/addr/id
//               Status    : mshr_full, mshr_count, resp_err
// Revision    : 1.0 - initial release
// ============================================================================
interface l1_mshr_miss_ctrl_if #(
    parameter int ADDR_W = 28,
    parameter int ID_W   = 2
);
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_dirty;
    logic [ADDR_W-1:0] victim_addr;
    logic              miss_ready;
    logic              miss_merged;
    logic              l2_req_valid;
    logic              l2_req_rw;
    logic [ADDR_W-1:0] l2_req_addr;
    logic [ID_W-1:0]   l2_req_id;
    logic              l2_req_stall;
    logic              l2_resp_valid;
    logic [ID_W-1:0]   l2_resp_id;
    logic              wb_rd_en;
    logic              fill_valid;
    logic [ADDR_W-1:0] fill_addr;
    logic [ID_W-1:0]   fill_id;
    logic              mshr_full;
    logic [ID_W:0]     mshr_count;
    logic              resp_err;

    modport slave (
        input  miss_valid, miss_addr, miss_dirty, victim_addr,
               l2_req_stall, l2_resp_valid, l2_resp_id,
        output miss_ready, miss_merged, l2_req_valid, l2_req_rw,
               l2_req_addr, l2_req_id, wb_rd_en, fill_valid, fill_addr,
               fill_id, mshr_full, mshr_count, resp_err
    );

    modport master (
        output miss_valid, miss_addr, miss_dirty, victim_addr,
               l2_req_stall, l2_resp_valid, l2_resp_id,
        input  miss_ready, miss_merged, l2_req_valid, l2_req_rw,
               l2_req_addr, l2_req_id, wb_rd_en, fill_valid, fill_addr,
               fill_id, mshr_full, mshr_count, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/l1_mshr_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : l1_mshr_miss_ctrl
// Description : Multi-entry L1 data-cache miss controller. Holds NUM_MSHR
//               miss entries, issues victim writeback then line read to L2
//               in entry-index order, and turns ID-tagged L2 responses into
//               one-cycle array fills.
//               Ports: clock, reset (sync, active-high), bus (slave modport
//               of l1_mshr_miss_ctrl_if carrying all miss/L2/fill/status).
//               Optional feature macro: L1_MSHR_MERGE_EN - merge secondary
//               misses to an outstanding line instead of blocking them.
// Revision    : 1.0 - initial release
// ============================================================================
module l1_mshr_miss_ctrl #(
    parameter int ADDR_W     = 28,
    parameter int NUM_MSHR   = 4,
    parameter int ID_W       = 2,
    parameter int L2_CLK_DIV = 1
) (
    input  wire logic          clock,
    input  wire logic          reset,
    l1_mshr_miss_ctrl_if.slave bus
);
    localparam int c_wb_cycles = 2 * L2_CLK_DIV;
    localparam int c_wb_w      = $clog2(c_wb_cycles + 1);
    localparam int c_cnt_w     = ID_W + 1;

    typedef enum logic [1:0] {E_FREE, E_PENDING, E_ISSUED} entry_state_t;
    typedef enum logic [1:0] {S_IDLE, S_WB_RD, S_WB_REQ, S_RD_REQ} issue_state_t;

    entry_state_t      r_state  [NUM_MSHR];
    logic [ADDR_W-1:0] r_addr   [NUM_MSHR];
    logic [ADDR_W-1:0] r_victim [NUM_MSHR];
    logic [NUM_MSHR-1:0] r_dirty;

    issue_state_t      r_issue, w_issue_nxt;
    logic [ID_W-1:0]   r_sel, w_sel_nxt;
    logic [c_wb_w-1:0] r_wb_cnt, w_wb_cnt_nxt;

    logic              r_fill_valid;
    logic [ADDR_W-1:0] r_fill_addr;
    logic [ID_W-1:0]   r_fill_id;
    logic              r_resp_err;
    logic [c_cnt_w-1:0] r_count;

    logic              w_full, w_ready, w_accept, w_alloc, w_match;
    logic [ID_W-1:0]   w_free_idx, w_pend_idx;
    logic              w_pend_found, w_resp_hit, w_rd_accept;
    logic              w_req_valid, w_req_rw, w_wb_rd_en;
    logic [ADDR_W-1:0] w_req_addr;

    // Scan high-to-low so the lowest index wins for both searches.
    always_comb begin
        w_match      = 1'b0;
        w_free_idx   = '0;
        w_pend_idx   = '0;
        w_pend_found = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (r_state[i] == E_FREE) begin
                w_free_idx = ID_W'(i);
            end
            if (r_state[i] == E_PENDING) begin
                w_pend_idx   = ID_W'(i);
                w_pend_found = 1'b1;
            end
            if (r_state[i] != E_FREE && r_addr[i] == bus.miss_addr) begin
                w_match = 1'b1;
            end
        end
    end

    // Count is registered, so a free in this cycle only lifts miss_ready next cycle.
    assign w_full = (r_count == c_cnt_w'(NUM_MSHR));

`ifdef L1_MSHR_MERGE_EN
    logic r_merged;
    assign w_ready = ~w_full | w_match;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_merged <= 1'b0;
        end else begin
            r_merged <= w_accept & w_match;
        end
    end
    assign bus.miss_merged = r_merged;
`else
    assign w_ready         = ~w_full & ~w_match;
    assign bus.miss_merged = 1'b0;
`endif

    assign w_accept   = bus.miss_valid & w_ready;
    assign w_alloc    = w_accept & ~w_match;
    assign w_resp_hit = bus.l2_resp_valid && (r_state[bus.l2_resp_id] == E_ISSUED);

    // Entry table: allocate, mark issued, free at the end of the fill cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                r_state[i]  <= E_FREE;
                r_addr[i]   <= '0;
                r_victim[i] <= '0;
            end
            r_dirty <= '0;
        end else begin
            for (int i = 0; i < NUM_MSHR; i++) begin
                if (w_alloc && w_free_idx == ID_W'(i)) begin
                    r_state[i]  <= E_PENDING;
                    r_addr[i]   <= bus.miss_addr;
                    r_victim[i] <= bus.victim_addr;
                    r_dirty[i]  <= bus.miss_dirty;
                end
                if (w_rd_accept && r_sel == ID_W'(i)) begin
                    r_state[i] <= E_ISSUED;
                end
                if (r_fill_valid && r_fill_id == ID_W'(i)) begin
                    r_state[i] <= E_FREE;
                end
            end
        end
    end

    // Fill path, occupancy count and sticky response error.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill_valid <= 1'b0;
            r_fill_addr  <= '0;
            r_fill_id    <= '0;
            r_resp_err   <= 1'b0;
            r_count      <= '0;
        end else begin
            r_fill_valid <= w_resp_hit;
            if (w_resp_hit) begin
                r_fill_addr <= r_addr[bus.l2_resp_id];
                r_fill_id   <= bus.l2_resp_id;
            end
            if (bus.l2_resp_valid && !w_resp_hit) begin
                r_resp_err <= 1'b1;
            end
            r_count <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(r_fill_valid);
        end
    end

    // Issue engine state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue  <= S_IDLE;
            r_sel    <= '0;
            r_wb_cnt <= '0;
        end else begin
            r_issue  <= w_issue_nxt;
            r_sel    <= w_sel_nxt;
            r_wb_cnt <= w_wb_cnt_nxt;
        end
    end

    // Issue engine next state and request outputs. The selected entry stays
    // PENDING until its read is accepted, so request fields hold under stall.
    always_comb begin
        w_issue_nxt  = r_issue;
        w_sel_nxt    = r_sel;
        w_wb_cnt_nxt = r_wb_cnt;
        w_req_valid  = 1'b0;
        w_req_rw     = 1'b0;
        w_req_addr   = '0;
        w_wb_rd_en   = 1'b0;
        w_rd_accept  = 1'b0;
        case (r_issue)
            S_IDLE: begin
                if (w_pend_found) begin
                    w_sel_nxt    = w_pend_idx;
                    w_wb_cnt_nxt = c_wb_w'(1);
                    w_issue_nxt  = r_dirty[w_pend_idx] ? S_WB_RD : S_RD_REQ;
                end
            end
            S_WB_RD: begin
                w_wb_rd_en = 1'b1;
                if (r_wb_cnt == c_wb_w'(c_wb_cycles)) begin
                    w_issue_nxt = S_WB_REQ;
                end else begin
                    w_wb_cnt_nxt = r_wb_cnt + c_wb_w'(1);
                end
            end
            S_WB_REQ: begin
                w_req_valid = 1'b1;
                w_req_rw    = 1'b1;
                w_req_addr  = r_victim[r_sel];
                if (!bus.l2_req_stall) begin
                    w_issue_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_req_valid = 1'b1;
                w_req_addr  = r_addr[r_sel];
                if (!bus.l2_req_stall) begin
                    w_rd_accept = 1'b1;
                    w_issue_nxt = S_IDLE;
                end
            end
            default: begin
                w_issue_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.miss_ready   = w_ready;
    assign bus.l2_req_valid = w_req_valid;
    assign bus.l2_req_rw    = w_req_rw;
    assign bus.l2_req_addr  = w_req_addr;
    assign bus.l2_req_id    = w_req_valid ? r_sel : '0;
    assign bus.wb_rd_en     = w_wb_rd_en;
    assign bus.fill_valid   = r_fill_valid;
    assign bus.fill_addr    = r_fill_addr;
    assign bus.fill_id      = r_fill_id;
    assign bus.mshr_full    = w_full;
    assign bus.mshr_count   = r_count;
    assign bus.resp_err     = r_resp_err;
endmodule
`default_nettype wire

// File: tb/tb_l1_mshr_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1_mshr_miss_ctrl
// Description : Directed self-checking bench for l1_mshr_miss_ctrl with
//               default parameters (4 entries, L2_CLK_DIV=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1_mshr_miss_ctrl;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    l1_mshr_miss_ctrl_if #(.ADDR_W(28), .ID_W(2)) bus ();

    l1_mshr_miss_ctrl #(
        .ADDR_W(28), .NUM_MSHR(4), .ID_W(2), .L2_CLK_DIV(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [1:0]  ids   [4] = '{2'd3, 2'd1, 2'd0, 2'd2};
    logic [27:0] addrs [4] = '{28'h40, 28'h20, 28'h10, 28'h50};
    int          wb_seen;

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.miss_valid    = 1'b0;
        bus.miss_addr     = '0;
        bus.miss_dirty    = 1'b0;
        bus.victim_addr   = '0;
        bus.l2_req_stall  = 1'b0;
        bus.l2_resp_valid = 1'b0;
        bus.l2_resp_id    = '0;

        // ---------------- reset state ----------------
        repeat (2) tick();
        settle();
        chk("rst_ready",  32'(bus.miss_ready), 32'd1);
        chk("rst_reqv",   32'(bus.l2_req_valid), 32'd0);
        chk("rst_wb",     32'(bus.wb_rd_en), 32'd0);
        chk("rst_fill",   32'(bus.fill_valid), 32'd0);
        chk("rst_full",   32'(bus.mshr_full), 32'd0);
        chk("rst_count",  32'(bus.mshr_count), 32'd0);
        chk("rst_err",    32'(bus.resp_err), 32'd0);
        chk("rst_merged", 32'(bus.miss_merged), 32'd0);
        reset = 1'b0;

        // ---------------- clean miss at 0x100 ----------------
        tick();                                   // cycle 0
        bus.miss_valid = 1'b1; bus.miss_addr = 28'h100; bus.miss_dirty = 1'b0;
        settle();
        chk("t1_ready", 32'(bus.miss_ready), 32'd1);
        tick(); bus.miss_valid = 1'b0; settle();  // cycle 1
        chk("t1_cnt1",  32'(bus.mshr_count), 32'd1);
        chk("t1_noreq", 32'(bus.l2_req_valid), 32'd0);
        tick(); settle();                         // cycle 2
        chk("t1_reqv",  32'(bus.l2_req_valid), 32'd1);
        chk("t1_rw",    32'(bus.l2_req_rw), 32'd0);
        chk("t1_addr",  32'(bus.l2_req_addr), 32'h100);
        chk("t1_id",    32'(bus.l2_req_id), 32'd0);
        tick(); settle();                         // cycle 3
        chk("t1_reqdrop", 32'(bus.l2_req_valid), 32'd0);
        repeat (4) tick();                        // cycle 7
        bus.l2_resp_valid = 1'b1; bus.l2_resp_id = 2'd0;
        settle();
        chk("t1_nofill", 32'(bus.fill_valid), 32'd0);
        tick(); bus.l2_resp_valid = 1'b0; settle(); // cycle 8
        chk("t1_fillv",  32'(bus.fill_valid), 32'd1);
        chk("t1_filla",  32'(bus.fill_addr), 32'h100);
        chk("t1_fillid", 32'(bus.fill_id), 32'd0);
        chk("t1_cnt_f",  32'(bus.mshr_count), 32'd1);
        tick(); settle();                         // cycle 9
        chk("t1_fillend", 32'(bus.fill_valid), 32'd0);
        chk("t1_cnt0",    32'(bus.mshr_count), 32'd0);

        // ---------------- dirty miss, writeback stalled 3 cycles ----------------
        tick();                                   // cycle 0
        bus.miss_valid = 1'b1; bus.miss_addr = 28'h300; bus.miss_dirty = 1'b1;
        bus.victim_addr = 28'h2A0;
        settle();
        tick(); bus.miss_valid = 1'b0; bus.miss_dirty = 1'b0; settle(); // cycle 1
        chk("t2_wb_c1", 32'(bus.wb_rd_en), 32'd0);
        wb_seen = 0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            bus.l2_req_stall = (c >= 4 && c <= 6);
            settle();
            if (bus.wb_rd_en) wb_seen++;
            chk("t2_wb", 32'(bus.wb_rd_en), 32'(c < 4));
            chk("t2_reqv", 32'(bus.l2_req_valid), 32'(c >= 4));
            if (c >= 4) begin
                chk("t2_rw1",  32'(bus.l2_req_rw), 32'd1);
                chk("t2_wbad", 32'(bus.l2_req_addr), 32'h2A0);
                chk("t2_wbid", 32'(bus.l2_req_id), 32'd0);
            end
        end
        chk("t2_wbcnt", 32'(wb_seen), 32'd2);
        tick(); bus.l2_req_stall = 1'b0; settle(); // cycle 8
        chk("t2_rdv",  32'(bus.l2_req_valid), 32'd1);
        chk("t2_rw0",  32'(bus.l2_req_rw), 32'd0);
        chk("t2_rdad", 32'(bus.l2_req_addr), 32'h300);
        tick();                                   // cycle 9
        bus.l2_resp_valid = 1'b1; bus.l2_resp_id = 2'd0;
        settle();
        chk("t2_done", 32'(bus.l2_req_valid), 32'd0);
        tick(); bus.l2_resp_valid = 1'b0; settle();
        chk("t2_fill", 32'(bus.fill_addr), 32'h300);
        tick(); settle();
        chk("t2_cnt0", 32'(bus.mshr_count), 32'd0);

        // ---------------- four misses fill the table, fifth waits ----------------
        for (int c = 0; c <= 14; c++) begin
            tick();
            if (c < 4) begin
                bus.miss_valid = 1'b1; bus.miss_addr = 28'(16 * (c + 1));
            end else if (c <= 12) begin
                bus.miss_valid = 1'b1; bus.miss_addr = 28'h50;
            end else begin
                bus.miss_valid = 1'b0;
            end
            bus.l2_resp_valid = (c == 10);
            bus.l2_resp_id    = 2'd2;
            settle();
            if (c < 4)               chk("t3_ready_hi", 32'(bus.miss_ready), 32'd1);
            if (c >= 4 && c <= 11)   chk("t3_ready_lo", 32'(bus.miss_ready), 32'd0);
            if (c == 12)             chk("t3_ready_re", 32'(bus.miss_ready), 32'd1);
            if (c == 4)              chk("t3_full", 32'(bus.mshr_full), 32'd1);
            if (c == 2 || c == 4 || c == 6 || c == 8) begin
                chk("t3_reqv",  32'(bus.l2_req_valid), 32'd1);
                chk("t3_reqid", 32'(bus.l2_req_id), 32'((c - 2) / 2));
                chk("t3_reqad", 32'(bus.l2_req_addr), 32'(16 * ((c - 2) / 2 + 1)));
            end else if (c == 14) begin
                chk("t3_5v",  32'(bus.l2_req_valid), 32'd1);
                chk("t3_5id", 32'(bus.l2_req_id), 32'd2);
                chk("t3_5ad", 32'(bus.l2_req_addr), 32'h50);
            end else if (c >= 3) begin
                chk("t3_reqlo", 32'(bus.l2_req_valid), 32'd0);
            end
            if (c == 11) begin
                chk("t3_fillv",  32'(bus.fill_valid), 32'd1);
                chk("t3_filla",  32'(bus.fill_addr), 32'h30);
                chk("t3_fillid", 32'(bus.fill_id), 32'd2);
            end
            if (c == 12) chk("t3_cnt3", 32'(bus.mshr_count), 32'd3);
            if (c == 13) chk("t3_cnt4", 32'(bus.mshr_count), 32'd4);
        end

        // ---------------- out-of-order responses 3,1,0,2 ----------------
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.l2_resp_valid = 1'b1; bus.l2_resp_id = ids[k];
            settle();
            tick(); bus.l2_resp_valid = 1'b0; settle();
            chk("t4_fillv",  32'(bus.fill_valid), 32'd1);
            chk("t4_fillid", 32'(bus.fill_id), 32'(ids[k]));
            chk("t4_filla",  32'(bus.fill_addr), 32'(addrs[k]));
        end
        tick(); settle();
        chk("t4_cnt0", 32'(bus.mshr_count), 32'd0);
        chk("t4_full", 32'(bus.mshr_full), 32'd0);
        chk("t4_err",  32'(bus.resp_err), 32'd0);

        // ---------------- second miss to a pending line ----------------
        tick();                                   // cycle 0
        bus.miss_valid = 1'b1; bus.miss_addr = 28'h77; bus.miss_dirty = 1'b0;
        settle();
        chk("t5_ready0", 32'(bus.miss_ready), 32'd1);
`ifdef L1_MSHR_MERGE_EN
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.miss_valid    = (c == 1);
            bus.l2_resp_valid = (c == 4);
            bus.l2_resp_id    = 2'd0;
            settle();
            if (c == 1) chk("t5_mready", 32'(bus.miss_ready), 32'd1);
            if (c == 2) chk("t5_merged", 32'(bus.miss_merged), 32'd1);
            if (c == 2) chk("t5_mcnt",   32'(bus.mshr_count), 32'd1);
            if (c == 3) chk("t5_mpulse", 32'(bus.miss_merged), 32'd0);
            chk("t5_mreqv", 32'(bus.l2_req_valid), 32'(c == 2));
        end
        tick(); settle();
        chk("t5_mcnt0", 32'(bus.mshr_count), 32'd0);
`else
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.miss_valid    = (c <= 6);
            bus.l2_resp_valid = (c == 4);
            bus.l2_resp_id    = 2'd0;
            settle();
            if (c <= 5) chk("t5_blocked", 32'(bus.miss_ready), 32'd0);
            if (c == 6) chk("t5_release", 32'(bus.miss_ready), 32'd1);
            if (c == 2) chk("t5_nomerge", 32'(bus.miss_merged), 32'd0);
            chk("t5_reqv", 32'(bus.l2_req_valid), 32'(c == 2 || c == 8));
            if (c == 8) chk("t5_req2ad", 32'(bus.l2_req_addr), 32'h77);
        end
        tick();
        bus.l2_resp_valid = 1'b1; bus.l2_resp_id = 2'd0;
        settle();
        tick(); bus.l2_resp_valid = 1'b0; settle();
        chk("t5_fill2", 32'(bus.fill_valid), 32'd1);
        tick(); settle();
        chk("t5_cnt0", 32'(bus.mshr_count), 32'd0);
`endif
        chk("t5_err", 32'(bus.resp_err), 32'd0);

        // ---------------- reset mid-request, stale response, reset clears ----------------
        tick();                                   // cycle 0
        bus.miss_valid = 1'b1; bus.miss_addr = 28'h99; bus.miss_dirty = 1'b0;
        bus.l2_req_stall = 1'b1;
        settle();
        tick(); bus.miss_valid = 1'b0; settle();  // cycle 1
        tick(); settle();                         // cycle 2
        chk("t6_stallv", 32'(bus.l2_req_valid), 32'd1);
        chk("t6_stalla", 32'(bus.l2_req_addr), 32'h99);
        tick(); reset = 1'b1; settle();           // cycle 3
        chk("t6_holdv", 32'(bus.l2_req_valid), 32'd1);
        tick(); reset = 1'b0; bus.l2_req_stall = 1'b0; settle(); // cycle 4
        chk("t6_dropv",  32'(bus.l2_req_valid), 32'd0);
        chk("t6_cnt0",   32'(bus.mshr_count), 32'd0);
        chk("t6_ready",  32'(bus.miss_ready), 32'd1);
        tick();                                   // cycle 5
        bus.l2_resp_valid = 1'b1; bus.l2_resp_id = 2'd0;
        settle();
        tick(); bus.l2_resp_valid = 1'b1; bus.l2_resp_id = 2'd1; settle(); // cycle 6
        chk("t6_nofill", 32'(bus.fill_valid), 32'd0);
        chk("t6_err",    32'(bus.resp_err), 32'd1);
        tick(); bus.l2_resp_valid = 1'b0; settle();
        chk("t6_nofill1", 32'(bus.fill_valid), 32'd0);
        repeat (3) tick();
        settle();
        chk("t6_sticky", 32'(bus.resp_err), 32'd1);
        reset = 1'b1;
        tick(); reset = 1'b0; settle();
        chk("t6_errclr", 32'(bus.resp_err), 32'd0);
        chk("t6_cntclr", 32'(bus.mshr_count), 32'd0);
        chk("t6_rdyclr", 32'(bus.miss_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
